alu_rr_sequencer: RTL

- Shares one 8-bit ALU datapath between two requesters using round-robin arbitration.
- Each request carries A, B and Op. The block captures the operands, executes the operation with a registered stage, and returns a tagged 16-bit result through a valid/ready response port.
- Sits between two operand sources (e.g. an instruction sequencer and a test/debug port) and the shared arithmetic unit.

---
 rtl/alu_rr_sequencer.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/alu_rr_sequencer.sv
// rtl/alu_rr_sequencer.sv - two-requester round-robin front end for a shared registered 8-bit ALU
// Optional response counters stat0_cnt/stat1_cnt are enabled by defining ALU_RR_STATS_EN.
module alu_rr_sequencer #(
  parameter int PRI_INIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  input  logic [2:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  input  logic [2:0]  req1_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_out,
  output logic        rsp_cb,
  output logic        busy
`ifdef ALU_RR_STATS_EN
  ,
  output logic [15:0] stat0_cnt,
  output logic [15:0] stat1_cnt
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_SHL = 3'b011;
  localparam logic [2:0] OP_SHR = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;
  localparam logic [2:0] OP_XOR = 3'b111;

  // Seeding last_grant with the opposite requester makes PRI_INIT win the first tie.
  localparam logic LAST_GRANT_INIT = (PRI_INIT == 0) ? 1'b1 : 1'b0;

  logic [1:0]  state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [2:0]  op_q, op_d;
  logic        id_q, id_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_id_q, rsp_id_d;
  logic [15:0] rsp_out_q, rsp_out_d;
  logic        rsp_cb_q, rsp_cb_d;

  logic        grant;
  logic [15:0] alu_out;
  logic        alu_cb;
  logic [8:0]  sum9;
  logic [8:0]  diff9;

  always_comb begin
    sum9    = {1'b0, a_q} + {1'b0, b_q};
    diff9   = {1'b0, a_q} - {1'b0, b_q};
    alu_out = '0;
    alu_cb  = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_out = {8'h00, sum9[7:0]};
        alu_cb  = sum9[8];
      end
      OP_SUB: begin
        alu_out = {8'h00, diff9[7:0]};
        alu_cb  = (a_q < b_q);
      end
      OP_MUL: alu_out = {8'h00, a_q} * {8'h00, b_q};
      OP_SHL: alu_out = (|b_q[7:3]) ? 16'h0000 : {8'h00, a_q << b_q[2:0]};
      OP_SHR: alu_out = (|b_q[7:3]) ? 16'h0000 : {8'h00, a_q >> b_q[2:0]};
      OP_AND: alu_out = {8'h00, a_q & b_q};
      OP_OR:  alu_out = {8'h00, a_q | b_q};
      OP_XOR: alu_out = {8'h00, a_q ^ b_q};
      default: alu_out = '0;
    endcase
  end

  always_comb begin
    grant        = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    req0_ready   = (state_q == IDLE) && !grant && req0_valid;
    req1_ready   = (state_q == IDLE) && grant && req1_valid;
    state_d      = state_q;
    last_grant_d = last_grant_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    id_d         = id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_out_d    = rsp_out_q;
    rsp_cb_d     = rsp_cb_q;
    case (state_q)
      IDLE: begin
        if (req0_ready || req1_ready) begin
          a_d          = grant ? req1_a : req0_a;
          b_d          = grant ? req1_b : req0_b;
          op_d         = grant ? req1_op : req0_op;
          id_d         = grant;
          last_grant_d = grant;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        rsp_out_d   = alu_out;
        rsp_cb_d    = alu_cb;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= LAST_GRANT_INIT;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_out_q    <= '0;
      rsp_cb_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_out_q    <= rsp_out_d;
      rsp_cb_q     <= rsp_cb_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_out   = rsp_out_q;
  assign rsp_cb    = rsp_cb_q;
  assign busy      = (state_q != IDLE);

`ifdef ALU_RR_STATS_EN
  logic [15:0] stat0_q, stat0_d;
  logic [15:0] stat1_q, stat1_d;
  logic        rsp_done;

  always_comb begin
    rsp_done = rsp_valid_q && rsp_ready;
    stat0_d  = stat0_q;
    stat1_d  = stat1_q;
    if (rsp_done && !rsp_id_q && (stat0_q != 16'hFFFF)) stat0_d = stat0_q + 16'd1;
    if (rsp_done && rsp_id_q && (stat1_q != 16'hFFFF))  stat1_d = stat1_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat0_q <= '0;
      stat1_q <= '0;
    end else begin
      stat0_q <= stat0_d;
      stat1_q <= stat1_d;
    end
  end

  assign stat0_cnt = stat0_q;
  assign stat1_cnt = stat1_q;
`endif

endmodule
